// File: rtl/record_packer.sv
// rtl/record_packer.sv - packs 32-bit words into 768-bit records for the DDR burst writer
// One assembly buffer plus a hold register (data/address) so assembly overlaps the write handshake.
module record_packer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_STEP   = 16,
    parameter int          NUM_RECORDS = 1024,
    parameter int          ACK_TIMEOUT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic         flush,
    input  logic         busy,
    output logic         write,
    output logic [767:0] data,
    output logic [31:0]  address,
    output logic [15:0]  record_count,
    output logic         ack_err
);

    localparam logic [31:0] STEP     = 32'(ADDR_STEP);
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(ADDR_STEP * NUM_RECORDS);
    localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    state_t         state, state_next;
    logic [767:0]   asm_buf, buf_next;
    logic [4:0]     idx, idx_after;
    logic           asm_full;
    logic [31:0]    next_addr, addr_inc;
    logic [7:0]     tcnt;
    logic           accept, transfer, flush_close;

    assign in_ready = !asm_full;
    assign accept   = in_valid && !asm_full;
    assign transfer = asm_full && (state == IDLE);
    assign addr_inc = next_addr + STEP;

    // The word accepted on this edge is placed first; flush padding then clears the slots after it.
    always_comb begin
        buf_next    = asm_buf;
        idx_after   = idx;
        flush_close = 1'b0;
        if (accept) begin
            buf_next[(23 - int'(idx)) * 32 +: 32] = in_data;
            idx_after = (idx == 5'd23) ? 5'd0 : idx + 5'd1;
        end
        if (!asm_full && flush && idx_after != 5'd0) begin
            flush_close = 1'b1;
            for (int k = 0; k < 24; k++) begin
                if (k >= int'(idx_after)) buf_next[(23 - k) * 32 +: 32] = 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_buf  <= '0;
            idx      <= 5'd0;
            asm_full <= 1'b0;
        end else if (transfer) begin
            asm_full <= 1'b0;
        end else if (!asm_full) begin
            asm_buf  <= buf_next;
            idx      <= flush_close ? 5'd0 : idx_after;
            asm_full <= flush_close || (accept && idx == 5'd23);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data         <= '0;
            address      <= 32'h0;
            next_addr    <= BASE_ADDR;
            record_count <= 16'h0;
        end else if (transfer) begin
            data         <= asm_buf;
            address      <= next_addr;
            next_addr    <= (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
            record_count <= record_count + 16'h1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (asm_full) state_next = ISSUE;
            ISSUE:   state_next = WAIT_HI;
            WAIT_HI: begin
                if (busy)                  state_next = WAIT_LO;
                else if (tcnt == TMO_LAST) state_next = ISSUE;
            end
            WAIT_LO: if (!busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            write   <= 1'b0;
            tcnt    <= 8'h0;
            ack_err <= 1'b0;
        end else begin
            state <= state_next;
            write <= (state_next == ISSUE);
            if (state == ISSUE)
                tcnt <= 8'h0;
            else if (state == WAIT_HI && !busy)
                tcnt <= tcnt + 8'h1;
            // A retry means the writer never acknowledged; remembered until reset.
            if (state == WAIT_HI && state_next == ISSUE)
                ack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_record_packer.sv
// tb/tb_record_packer.sv - directed bench for record_packer with a burst-writer busy model
// A second instance with NUM_RECORDS=2 shares all stimulus to observe address wrap.
module tb_record_packer;

    logic         clk = 1'b0;
    logic         reset, in_valid, flush;
    logic [31:0]  in_data;
    logic         in_ready, write, ack_err;
    logic [767:0] data;
    logic [31:0]  address;
    logic [15:0]  record_count;
    logic         in_ready2, write2, ack_err2;
    logic [767:0] data2;
    logic [31:0]  address2;
    logic [15:0]  record_count2;
    logic         busy;

    record_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .busy(busy), .write(write), .data(data), .address(address),
        .record_count(record_count), .ack_err(ack_err)
    );

    record_packer #(.NUM_RECORDS(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .flush(flush), .busy(busy), .write(write2), .data(data2), .address(address2),
        .record_count(record_count2), .ack_err(ack_err2)
    );

    always #5 clk = ~clk;

    int  hold_len   = 10;
    bit  drop_first = 1'b0;
    bit  dropped;
    int  bcnt;
    assign busy = (bcnt != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt    <= 0;
            dropped <= 1'b0;
        end else if (write && drop_first && !dropped) begin
            dropped <= 1'b1;
        end else if (write) begin
            bcnt <= hold_len;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end

    int           cyc = 0;
    int           wr_cnt = 0, stall = 0, busy_viol = 0, stab_viol = 0;
    logic [31:0]  wr_addr[$], wr_addr2[$];
    int           wr_cyc[$];
    logic [767:0] wr_data[$];
    logic [767:0] held_data = '0;
    logic [31:0]  held_addr = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (write) begin
                wr_cnt++;
                wr_addr.push_back(address);
                wr_addr2.push_back(address2);
                wr_cyc.push_back(cyc);
                wr_data.push_back(data);
                if (busy) busy_viol++;
                held_data = data;
                held_addr = address;
            end else if (busy && (data !== held_data || address !== held_addr)) begin
                stab_viol++;
            end
            if (!in_ready) stall++;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [767:0] got, input logic [767:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [767:0] rec(input int first, input int n);
        logic [767:0] r = '0;
        for (int k = 0; k < n; k++) r[(23 - k) * 32 +: 32] = 32'(first + k);
        return r;
    endfunction

    task automatic put(input logic [31:0] w);
        int t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("put_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (wr_cnt < n && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (wr_cnt < n) chk("write_seen", wr_cnt, n);
        while (busy && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int b, s, bv, sv;

    initial begin
        in_valid = 1'b0;
        in_data  = 32'h0;
        flush    = 1'b0;
        do_reset();
        chk("rst_ctrl", {in_ready, write, ack_err}, 3'b100);
        chk("rst_data", data, '0);
        chk("rst_addr", address, 32'h0);
        chk("rst_count", record_count, 16'h0);

        // single record, in_valid held high
        b = wr_cnt; s = stall;
        for (int i = 1; i <= 24; i++) put(32'(i));
        wait_writes(b + 1);
        chk("t1_writes", wr_cnt - b, 1);
        chk("t1_data", wr_data[b], rec(1, 24));
        chk("t1_first_last", {data[767:736], data[31:0]}, {32'd1, 32'd24});
        chk("t1_addr", wr_addr[b], 32'h0);
        chk("t1_count", record_count, 16'd1);
        chk("t1_bubble", stall - s, 1);

        // three back-to-back records with a slow writer
        do_reset();
        hold_len = 60;
        b = wr_cnt; s = stall; bv = busy_viol; sv = stab_viol;
        for (int i = 1; i <= 72; i++) put(32'(i));
        wait_writes(b + 3);
        chk("t2_writes", wr_cnt - b, 3);
        chk("t2_addrs", {wr_addr[b], wr_addr[b+1], wr_addr[b+2]}, {32'd0, 32'd16, 32'd32});
        chk("t2_wrap_addrs", {wr_addr2[b], wr_addr2[b+1], wr_addr2[b+2]}, {32'd0, 32'd16, 32'd0});
        chk("t2_rec3", wr_data[b+2], rec(49, 24));
        chk("t2_counts", {record_count, record_count2}, {16'd3, 16'd3});
        chk("t2_write_in_busy", busy_viol - bv, 0);
        chk("t2_stable", stab_viol - sv, 0);
        chk("t2_stalled", (stall - s) >= 30, 1'b1);

        // partial record closed by flush on the same edge as word 5, over stale buffer contents
        hold_len = 10;
        b = wr_cnt;
        for (int i = 1; i <= 4; i++) put(32'(i));
        flush = 1'b1;
        put(32'd5);
        flush = 1'b0;
        wait_writes(b + 1);
        chk("t3_writes", wr_cnt - b, 1);
        chk("t3_data", wr_data[b], rec(1, 5));
        chk("t3_addr", wr_addr[b], 32'd48);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("t3_empty_flush", wr_cnt - b, 1);
        chk("t3_count", record_count, 16'd4);

        // writer ignores the first request
        do_reset();
        drop_first = 1'b1;
        b = wr_cnt;
        for (int i = 0; i < 24; i++) put(32'(100 + i));
        wait_writes(b + 2);
        chk("t4_writes", wr_cnt - b, 2);
        chk("t4_gap", wr_cyc[b+1] - wr_cyc[b], 5);
        chk("t4_addrs", {wr_addr[b], wr_addr[b+1]}, {32'd0, 32'd0});
        chk("t4_data0", wr_data[b], rec(100, 24));
        chk("t4_data1", wr_data[b+1], rec(100, 24));
        chk("t4_ack_err", ack_err, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_ack_sticky", ack_err, 1'b1);
        drop_first = 1'b0;

        // reset during WAIT_LO with the next record half assembled
        do_reset();
        hold_len = 30;
        b = wr_cnt;
        for (int i = 1; i <= 36; i++) put(32'(i));
        chk("t6_in_wait_lo", {busy, 32'(wr_cnt - b)}, {1'b1, 32'd1});
        reset = 1'b1;
        #1;
        chk("t6_rst_ctrl", {in_ready, write, ack_err}, 3'b100);
        chk("t6_rst_data", data, '0);
        chk("t6_rst_addr_cnt", {address, record_count}, 48'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        b = wr_cnt;
        for (int i = 0; i < 24; i++) put(32'(200 + i));
        wait_writes(b + 1);
        chk("t6_writes", wr_cnt - b, 1);
        chk("t6_rec", {wr_addr[b], record_count, data[767:736]}, {32'd0, 16'd1, 32'd200});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
